// File: rtl/beep_scheduler.sv
// rtl/beep_scheduler.sv - fixed-priority three-requester buzzer tone scheduler
//
// Shares one active-low (PNP-driven) buzzer between three tone requesters.
// Each request carries a half-period (pitch) and a duration in ticks. The
// lowest-index request wins. The tone is played for the duration, followed by
// a silent gap, and then a one-cycle done pulse is sent to the served requester.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   req_i[2:0]     level requests, bit 0 highest priority
//   half_period_i  packed half-periods, requester i at [i*HP_W +: HP_W]
//   duration_i     packed durations in ticks, requester i at [i*DUR_W +: DUR_W]
//   mute_i         forces the buzzer off without disturbing sequencing
//   grant_o[2:0]   one-hot requester being served
//   done_o[2:0]    one-cycle pulse on the last gap cycle
//   busy_o         high whenever the scheduler is not idle
//   beep_o         registered active-low buzzer drive (1 = silent)
module beep_scheduler #(
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 20,
    parameter int HP_W      = 16,
    parameter int DUR_W     = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [2:0]           req_i,
    input  logic [3*HP_W-1:0]    half_period_i,
    input  logic [3*DUR_W-1:0]   duration_i,
    input  logic                 mute_i,
    output logic [2:0]           grant_o,
    output logic [2:0]           done_o,
    output logic                 busy_o,
    output logic                 beep_o
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int GAP_W  = $clog2(GAP_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP
    } state_e;

    state_e             state_q;
    logic [2:0]         grant_q;
    logic [2:0]         done_q;
    logic               busy_q;
    logic               beep_q;
    logic [HP_W-1:0]    hp_q;
    logic [DUR_W-1:0]   dur_q;
    logic [TICK_W-1:0]  tick_q;
    logic [DUR_W-1:0]   dur_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [HP_W-1:0]    tone_cnt_q;
    logic               tone_lvl_q;

    logic [1:0]         sel_idx;
    logic [2:0]         sel_oh;
    logic [HP_W-1:0]    sel_hp;
    logic [DUR_W-1:0]   sel_dur;
    logic               tick_wrap;
    logic               play_end;
    logic               gap_last_tick;
    logic               gap_end;
    logic               gap_pre_end;
    logic               tone_wrap;

    always_comb begin
        sel_idx = 2'd0;
        sel_oh  = 3'b000;
        if (req_i[0]) begin
            sel_idx = 2'd0;
            sel_oh  = 3'b001;
        end else if (req_i[1]) begin
            sel_idx = 2'd1;
            sel_oh  = 3'b010;
        end else if (req_i[2]) begin
            sel_idx = 2'd2;
            sel_oh  = 3'b100;
        end
        sel_hp  = half_period_i[sel_idx*HP_W +: HP_W];
        sel_dur = duration_i[sel_idx*DUR_W +: DUR_W];

        tick_wrap     = (tick_q == TICK_W'(TICK_DIV - 1));
        // A zero duration still spends a single cycle in PLAY.
        play_end      = (dur_q == '0) ||
                        (tick_wrap && (dur_cnt_q == dur_q - DUR_W'(1)));
        gap_last_tick = (gap_cnt_q == GAP_W'(GAP_TICKS - 1));
        gap_end       = tick_wrap && gap_last_tick;
        // done is registered, so it is launched one cycle ahead of gap_end.
        gap_pre_end   = gap_last_tick && (tick_q == TICK_W'(TICK_DIV - 2));
        tone_wrap     = (tone_cnt_q == hp_q - HP_W'(1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            beep_q     <= 1'b1;
            hp_q       <= '0;
            dur_q      <= '0;
            tick_q     <= '0;
            dur_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            tone_cnt_q <= '0;
            tone_lvl_q <= 1'b0;
        end else begin
            beep_q <= ~(tone_lvl_q & (state_q == S_PLAY)) | mute_i;
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (|req_i) begin
                        state_q    <= S_PLAY;
                        busy_q     <= 1'b1;
                        grant_q    <= sel_oh;
                        hp_q       <= sel_hp;
                        dur_q      <= sel_dur;
                        tick_q     <= '0;
                        dur_cnt_q  <= '0;
                        tone_cnt_q <= '0;
                        // A zero half-period is a silent note.
                        tone_lvl_q <= (sel_hp != '0);
                    end
                end
                S_PLAY: begin
                    if (play_end) begin
                        state_q    <= S_GAP;
                        tick_q     <= '0;
                        gap_cnt_q  <= '0;
                        tone_lvl_q <= 1'b0;
                    end else begin
                        tick_q <= tick_wrap ? '0 : tick_q + TICK_W'(1);
                        if (tick_wrap) begin
                            dur_cnt_q <= dur_cnt_q + DUR_W'(1);
                        end
                        if (hp_q == '0) begin
                            tone_lvl_q <= 1'b0;
                        end else if (tone_wrap) begin
                            tone_lvl_q <= ~tone_lvl_q;
                            tone_cnt_q <= '0;
                        end else begin
                            tone_cnt_q <= tone_cnt_q + HP_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        grant_q <= '0;
                    end else begin
                        tick_q <= tick_wrap ? '0 : tick_q + TICK_W'(1);
                        if (tick_wrap) begin
                            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                        end
                        if (gap_pre_end) begin
                            done_q <= grant_q;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant_o = grant_q;
    assign done_o  = done_q;
    assign busy_o  = busy_q;
    assign beep_o  = beep_q;

endmodule
